serial_rx_fifo: RTL

Receive-side byte buffer that sits directly downstream of the serial receiver. Each assertion of the receiver's data-ready level is converted into one write of the receiver's parallel byte, which goes into a first-word-fall-through FIFO. The CPU bus side pops bytes with a single-cycle read strobe. The block also reports empty, full, fill count and a sticky overrun flag.

---
 rtl/serial_pkg.sv | 16 +
 rtl/serial_edge_sync.sv | 47 ++++
 rtl/serial_rx_fifo.sv | 92 +++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared constants and width helpers for the serial block family.
package serial_pkg;

   localparam int SER_DATA_W        = 8;
   localparam int SER_RX_FIFO_DEPTH = 8;

   // Count must represent 0..depth inclusive; pointers only 0..depth-1.
   function automatic int ser_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ser_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/serial_edge_sync.sv
// Rising-edge detector on the receiver ready level, with an optional 2-flop
// synchronizer in front (enabled by defining SERIAL_RX_FIFO_SYNC_EN).
module serial_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic d_in,
   output logic pulse_out
);

   logic src;
   logic d_q;
   logic armed;

`ifdef SERIAL_RX_FIFO_SYNC_EN
   logic sync_1;
   logic sync_2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= d_in;
         sync_2 <= sync_1;
      end
   end

   assign src = sync_2;
`else
   assign src = d_in;
`endif

   // armed stays low until the level has been seen low once after reset, so a
   // ready level already high at reset release never counts as an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_q   <= 1'b0;
         armed <= 1'b0;
      end else begin
         d_q   <= src;
         armed <= armed | ~src;
      end
   end

   assign pulse_out = src & ~d_q & armed;

endmodule

// File: rtl/serial_rx_fifo.sv
// First-word-fall-through receive byte FIFO with sticky overrun flag.
// Optional input synchronizer: define SERIAL_RX_FIFO_SYNC_EN.
module serial_rx_fifo
   import serial_pkg::*;
#(
   parameter int DEPTH = SER_RX_FIFO_DEPTH,
   parameter int WIDTH = SER_DATA_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [WIDTH-1:0]              rx_data,
   input  logic                          rx_rdy,
   input  logic                          rd,
   input  logic                          clr_ovr,
   output logic [WIDTH-1:0]              dout,
   output logic                          empty,
   output logic                          full,
   output logic [ser_cnt_w(DEPTH)-1:0]   count,
   output logic                          overrun
);

   localparam int CNT_W = ser_cnt_w(DEPTH);
   localparam int PTR_W = ser_ptr_w(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_ev;
   logic             rd_ok;
   logic             wr_ok;
   logic             drop;

   serial_edge_sync u_edge (
      .clk       (clk),
      .reset     (reset),
      .d_in      (rx_rdy),
      .pulse_out (wr_ev)
   );

   assign empty = (count == '0);
   assign full  = (count == CNT_FULL);
   assign dout  = mem[rd_ptr];

   // A simultaneous pop frees the slot, so a write into a full FIFO is kept.
   assign rd_ok = rd & ~empty;
   assign wr_ok = wr_ev & (~full | rd_ok);
   assign drop  = wr_ev & full & ~rd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (clr_ovr) begin
         overrun <= 1'b0;
      end
   end

endmodule
